seq_alu: RTL
============

# seq_alu

Parametrised, registered successor to the CPU's 8-bit combinational ALU: same 3-bit SELECT operation encoding, generalised to WIDTH bits, with registered outputs, a START/BUSY/DONE handshake, an iterative shift-add multiplier, full-range shift amounts and a signed-overflow flag. It sits between the register file read ports and the write-back path. The control unit issues one operation at a time and waits for DONE before writing RESULT back.

## Interface
- WIDTH, default 8: operand and result width; power of two, 4..64.
- SHW, default $clog2(WIDTH): shift-amount width; derived, not overridden.

- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only while BUSY=0.
- SELECT  input  3  operation code, latched with START.
- DATA1  input  WIDTH  operand A, latched with START.
- DATA2  input  WIDTH  operand B or shift amount, latched with START.
- RESULT  output  WIDTH  registered result; holds until the next completion.
- ZERO  output  1  registered; 1 when RESULT == 0, updated together with RESULT.
- OVF  output  1  registered signed overflow of ADD; 0 after any other operation.
- BUSY  output  1  1 while a multiply is in progress.
- DONE  output  1  single-cycle pulse; RESULT, ZERO and OVF are valid and new.

## Operation
- SELECT encoding (unchanged from the CPU ALU):
  - 000 FWD: DATA2.
  - 001 ADD: DATA1+DATA2, mod 2^WIDTH.
  - 010 AND.
  - 011 OR.
  - 100 SLL: DATA1 << DATA2[SHW-1:0], zero fill.
  - 101 SRL: DATA1 >> DATA2[SHW-1:0], zero fill.
  - 110 MUL: low WIDTH bits of DATA1*DATA2. These bits are identical for signed and unsigned operands.
  - 111 ROR: DATA1 rotated right by DATA2[SHW-1:0].
- DATA2 bits above SHW are ignored for shifts and rotates. A shift amount of 0 returns DATA1.
- OVF for ADD: both operands have the same sign and the sum's sign differs from it.
- State machine has two states, IDLE and MUL:
  - IDLE, START=1, SELECT≠110: compute combinationally from the inputs and register RESULT, ZERO, OVF with DONE=1 on this edge. Stay in IDLE.
  - IDLE, START=1, SELECT=110: latch the multiplicand, latch the multiplier, clear the accumulator, set the counter to 0, BUSY=1, go to MUL.
  - MUL, each edge: if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
  - MUL, edge on which the counter reaches WIDTH: load RESULT from the accumulator, set ZERO, OVF=0, DONE=1, BUSY=0, go to IDLE.
- While BUSY=1, START, SELECT, DATA1 and DATA2 are ignored. Input changes do not affect the running multiply.
- DONE is cleared on every edge where no completion occurs.
- Reset values: RESULT=0, ZERO=1, OVF=0, BUSY=0, DONE=0, state IDLE. Internal multiplier registers and counter are 0.

## Timing
- Single-cycle operations: START sampled at edge N, so RESULT and DONE are visible after edge N. Latency is 1 cycle and BUSY stays 0.
- MUL: START sampled at edge N. BUSY is 1 after edges N..N+WIDTH-1. RESULT and DONE appear after edge N+WIDTH, with BUSY=0 in the same cycle.
- MUL latency is fixed at WIDTH cycles regardless of operand values, including 0 and 1.
- Back-to-back operation: START may be high in the cycle DONE is high, since state is IDLE. The new operation is accepted at that edge.
- A single-cycle operation can therefore complete on every edge.
- RESET asserted mid-multiply aborts immediately and asynchronously to reset values. No DONE is produced for the aborted operation.
- START held high while BUSY does not queue a request. It is re-sampled only once BUSY=0.

## Test plan
- Reset, WIDTH=8: assert RESET low mid-MUL (3 cycles after START) -> BUSY=0, DONE=0, RESULT=0x00, ZERO=1 immediately. No DONE is seen after RESET is released.
- ADD, WIDTH=8: DATA1=0x7F, DATA2=0x01, START -> next cycle RESULT=0x80, OVF=1, ZERO=0, DONE=1. Then 0xFF+0x01 -> RESULT=0x00, ZERO=1, OVF=0.
- MUL, WIDTH=8: DATA1=0xFD (-3), DATA2=0x05 -> BUSY high for exactly 8 cycles, then RESULT=0xF1 (-15) and DONE pulses once. Change DATA1/DATA2 while BUSY -> result unchanged.
- Shifts, WIDTH=8: SLL 0x81 by DATA2=0x09 (amount 1) -> 0x02. SRL 0x80 by 7 -> 0x01. ROR 0x01 by 1 -> 0x80. Shift by 0 -> 0x81.
- Back-to-back: a MUL, then START of AND 0xF0&0x3C in the DONE cycle -> AND accepted with RESULT=0x30 one cycle later. START pulsed while BUSY -> ignored.
- WIDTH=32 instance: MUL 0x00010000*0x00010000 -> RESULT=0x00000000, ZERO=1 after 32 cycles. ROR 0x00000001 by 31 -> 0x00000002.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Registered WIDTH-bit ALU with a START/BUSY/DONE handshake.
//            Single-cycle ops (FWD/ADD/AND/OR/SLL/SRL/ROR) complete on the
//            edge that samples START; MUL runs an iterative shift-add for
//            exactly WIDTH cycles.
// Ports    : CLK     - clock, rising edge
//            RESET   - asynchronous, active-low reset
//            START   - operation request, sampled only while BUSY=0
//            SELECT  - 3-bit operation code, latched with START
//            DATA1   - operand A
//            DATA2   - operand B / shift amount (low SHW bits)
//            RESULT  - registered result, held until the next completion
//            ZERO    - RESULT == 0
//            OVF     - signed overflow of the last ADD, else 0
//            BUSY    - multiply in progress
//            DONE    - one-cycle pulse when RESULT/ZERO/OVF are new
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  // Counter must be able to represent WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] C_OP_FWD = 3'b000;
  localparam logic [2:0] C_OP_ADD = 3'b001;
  localparam logic [2:0] C_OP_AND = 3'b010;
  localparam logic [2:0] C_OP_OR  = 3'b011;
  localparam logic [2:0] C_OP_SLL = 3'b100;
  localparam logic [2:0] C_OP_SRL = 3'b101;
  localparam logic [2:0] C_OP_MUL = 3'b110;
  localparam logic [2:0] C_OP_ROR = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_mcand,  w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [WIDTH-1:0] r_acc,    w_acc_nxt;
  logic [CW-1:0]    r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_zero,   w_zero_nxt;
  logic             r_ovf,    w_ovf_nxt;
  logic             r_done,   w_done_nxt;

  // --------------------------------------------------------------------------
  // Single-cycle datapath, driven straight from the inputs
  // --------------------------------------------------------------------------
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_sum;
  logic [2*WIDTH-1:0] w_ror2;
  logic [WIDTH-1:0]   w_alu;
  logic               w_add_ovf;

  assign w_shamt = DATA2[SHW-1:0];
  assign w_sum   = DATA1 + DATA2;
  // Rotating a doubled copy avoids a special case for a zero shift amount.
  assign w_ror2  = {DATA1, DATA1} >> w_shamt;

  assign w_add_ovf = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != DATA1[WIDTH-1]);

  always_comb begin
    w_alu = '0;
    case (SELECT)
      C_OP_FWD: w_alu = DATA2;
      C_OP_ADD: w_alu = w_sum;
      C_OP_AND: w_alu = DATA1 & DATA2;
      C_OP_OR:  w_alu = DATA1 | DATA2;
      C_OP_SLL: w_alu = DATA1 << w_shamt;
      C_OP_SRL: w_alu = DATA1 >> w_shamt;
      C_OP_ROR: w_alu = w_ror2[WIDTH-1:0];
      default:  w_alu = '0;  // MUL is handled by the iterative path
    endcase
  end

  // Accumulator value after this edge's conditional add.
  logic [WIDTH-1:0] w_acc_step;
  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_ovf_nxt    = r_ovf;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          if (SELECT == C_OP_MUL) begin
            w_mcand_nxt  = DATA1;
            w_mplier_nxt = DATA2;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_MUL;
          end else begin
            w_result_nxt = w_alu;
            w_zero_nxt   = (w_alu == '0);
            w_ovf_nxt    = (SELECT == C_OP_ADD) && w_add_ovf;
            w_done_nxt   = 1'b1;
          end
        end
      end

      S_MUL: begin
        w_acc_nxt    = w_acc_step;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + CW'(1);
        // The counter reaches WIDTH on this edge: the final add is folded in.
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_result_nxt = w_acc_step;
          w_zero_nxt   = (w_acc_step == '0);
          w_ovf_nxt    = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_ovf    <= w_ovf_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign RESULT = r_result;
  assign ZERO   = r_zero;
  assign OVF    = r_ovf;
  assign BUSY   = (r_state == S_MUL);
  assign DONE   = r_done;

endmodule
`default_nettype wire
